lpc_host_initiator: RTL and testbench

- LPC host-side initiator; the opposite end of the LPC peripheral controller in the FPGA IP.
- Issues single-byte LPC I/O and TPM-locality read/write cycles on LAD[3:0]/LFRAME#.
- Handles SYNC waits, errors, no-response timeout and abort.
- Driven by a simple request/done interface from a Wishbone-facing register block or a bench sequencer; used for loopback testing of the peripheral controller.

---
 rtl/lpc_host_initiator.sv | 253 +++++++++++++++++++++++++
 tb/tb_lpc_host_initiator.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_host_initiator.sv
// LPC host-side initiator. Issues single-byte LPC I/O and TPM-locality read/write cycles
// on LAD[3:0]/LFRAME#, handles SYNC waits, errors, no-response timeout and abort.
//
// Ports:
//   LPC_CLK_i, LPC_RST_n_i    : LPC clock (rising edge), asynchronous active-low reset
//   req_i, req_we_i, req_tpm_i: start request (sampled only when idle), direction, cycle type
//   req_addr_i, req_wdata_i   : cycle address and write data
//   busy_o, done_o            : transaction in progress, one-cycle completion pulse
//   rdata_o, status_o         : read data / completion status (00 ok, 01 SYNC error,
//                               10 timeout/no-response, 11 illegal SYNC)
//   LAD_i, LAD_o, LAD_oe_o    : LAD pad input, output and output enable
//   LFRAME_n_o                : LFRAME#, active-low
module lpc_host_initiator #(
  parameter int unsigned NORESP_CYCLES = 4,
  parameter int unsigned WAIT_MAX      = 1023,
  parameter int unsigned CNTR_WIDTH    = 10
) (
  input  logic        LPC_CLK_i,
  input  logic        LPC_RST_n_i,
  input  logic        req_i,
  input  logic        req_we_i,
  input  logic        req_tpm_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  rdata_o,
  output logic [1:0]  status_o,
  input  logic [3:0]  LAD_i,
  output logic [3:0]  LAD_o,
  output logic        LAD_oe_o,
  output logic        LFRAME_n_o
);

  localparam int unsigned NrWidth = $clog2(NORESP_CYCLES + 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StCycDir, StAddr, StWdata, StTar1, StTar2, StSync,
    StRdata, StPtar1, StPtar2, StAbort, StAbortEnd
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;       // nibble index within ADDR/WDATA/RDATA/ABORT
  logic                  we_q, we_d;
  logic                  tpm_q, tpm_d;
  logic [15:0]           addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [CNTR_WIDTH-1:0] wait_q, wait_d;
  logic [NrWidth-1:0]    nr_q, nr_d;
  logic [1:0]            cst_q, cst_d;       // status of the cycle in flight
  logic [7:0]            rsh_q, rsh_d;       // read data being assembled

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [7:0]            rdata_q, rdata_d;
  logic [1:0]            status_q, status_d;
  logic [3:0]            lad_q, lad_d;
  logic                  oe_q, oe_d;
  logic                  lframe_q, lframe_d;

  // Next-state and cycle bookkeeping.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    we_d     = we_q;
    tpm_d    = tpm_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    nr_d     = nr_q;
    cst_d    = cst_q;
    rsh_d    = rsh_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    status_d = status_q;

    case (state_q)
      StIdle: begin
        if (req_i) begin
          we_d    = req_we_i;
          tpm_d   = req_tpm_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          idx_d   = 2'd0;
          wait_d  = '0;
          nr_d    = '0;
          cst_d   = 2'b00;
          state_d = StStart;
        end
      end
      StStart:  state_d = StCycDir;
      StCycDir: begin
        idx_d   = 2'd0;
        state_d = StAddr;
      end
      StAddr: begin
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          state_d = we_q ? StWdata : StTar1;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StWdata: begin
        if (idx_q == 2'd1) begin
          idx_d   = 2'd0;
          state_d = StTar1;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StTar1: state_d = StTar2;
      StTar2: state_d = StSync;
      StSync: begin
        idx_d = 2'd0;
        case (LAD_i)
          4'h0, 4'hA: begin
            cst_d   = (LAD_i == 4'hA) ? 2'b01 : 2'b00;
            state_d = we_q ? StPtar1 : StRdata;
          end
          4'h5, 4'h6: begin
            nr_d = '0;
            if (wait_q != '1) wait_d = wait_q + 1'b1;
            if (wait_d >= CNTR_WIDTH'(WAIT_MAX)) begin
              cst_d   = 2'b10;
              state_d = StAbort;
            end
          end
          4'hF: begin
            if (nr_q != '1) nr_d = nr_q + 1'b1;
            if (nr_d >= NrWidth'(NORESP_CYCLES)) begin
              cst_d   = 2'b10;
              state_d = StAbort;
            end
          end
          default: begin
            cst_d   = 2'b11;
            state_d = StAbort;
          end
        endcase
      end
      StRdata: begin
        if (idx_q == 2'd0) begin
          rsh_d[3:0] = LAD_i;
          idx_d      = 2'd1;
        end else begin
          rsh_d[7:4] = LAD_i;
          idx_d      = 2'd0;
          state_d    = StPtar1;
        end
      end
      StPtar1: state_d = StPtar2;
      StPtar2: begin
        state_d  = StIdle;
        done_d   = 1'b1;
        status_d = cst_q;
        if (!we_q) rdata_d = rsh_q;
      end
      StAbort: begin
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          state_d = StAbortEnd;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StAbortEnd: begin
        // rdata_o deliberately keeps the previous transaction's value.
        state_d  = StIdle;
        done_d   = 1'b1;
        status_d = cst_q;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pad outputs are decoded from the next state so they can be registered with it.
  always_comb begin
    lad_d    = 4'hF;
    oe_d     = 1'b1;
    lframe_d = 1'b1;
    busy_d   = (state_d != StIdle);

    case (state_d)
      StStart: begin
        lframe_d = 1'b0;
        lad_d    = tpm_d ? 4'h5 : 4'h0;
      end
      StCycDir: lad_d = {2'b00, we_d, 1'b0};
      StAddr: begin
        case (idx_d)
          2'd0:    lad_d = addr_d[15:12];
          2'd1:    lad_d = addr_d[11:8];
          2'd2:    lad_d = addr_d[7:4];
          default: lad_d = addr_d[3:0];
        endcase
      end
      StWdata: lad_d = (idx_d == 2'd0) ? wdata_d[3:0] : wdata_d[7:4];
      StTar2, StSync, StRdata, StPtar1, StPtar2: oe_d = 1'b0;
      StAbort: lframe_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge LPC_CLK_i or negedge LPC_RST_n_i) begin
    if (!LPC_RST_n_i) begin
      state_q  <= StIdle;
      idx_q    <= 2'd0;
      we_q     <= 1'b0;
      tpm_q    <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      wait_q   <= '0;
      nr_q     <= '0;
      cst_q    <= 2'b00;
      rsh_q    <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= 8'h00;
      status_q <= 2'b00;
      lad_q    <= 4'hF;
      oe_q     <= 1'b1;
      lframe_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      tpm_q    <= tpm_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      nr_q     <= nr_d;
      cst_q    <= cst_d;
      rsh_q    <= rsh_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      lad_q    <= lad_d;
      oe_q     <= oe_d;
      lframe_q <= lframe_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rdata_o    = rdata_q;
  assign status_o   = status_q;
  assign LAD_o      = lad_q;
  assign LAD_oe_o   = oe_q;
  assign LFRAME_n_o = lframe_q;

endmodule

// File: tb/tb_lpc_host_initiator.sv
// Self-checking bench for lpc_host_initiator: directed vector table, reset corner case and
// randomized transactions compared against a cycle-trace model built from the LPC rules.
module tb_lpc_host_initiator;

  localparam int WaitMax = 1023;
  localparam int NoResp  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, req_we_i, req_tpm_i;
  logic [15:0] req_addr_i;
  logic [7:0]  req_wdata_i;
  logic        busy_o, done_o;
  logic [7:0]  rdata_o;
  logic [1:0]  status_o;
  logic [3:0]  lad_in, lad_out;
  logic        lad_oe, lframe_n;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] rd_model = 8'h00;

  always #5 clk = ~clk;

  lpc_host_initiator dut (
    .LPC_CLK_i  (clk),
    .LPC_RST_n_i(rst_n),
    .req_i      (req_i),
    .req_we_i   (req_we_i),
    .req_tpm_i  (req_tpm_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rdata_o    (rdata_o),
    .status_o   (status_o),
    .LAD_i      (lad_in),
    .LAD_o      (lad_out),
    .LAD_oe_o   (lad_oe),
    .LFRAME_n_o (lframe_n)
  );

  // One expected bus cycle: LFRAME#, oe, driven nibble, and what the peripheral presents.
  typedef struct packed {
    logic       lf;
    logic       oe;
    logic [3:0] lad;
    logic [3:0] din;
  } tr_t;

  tr_t trace_q[$];

  typedef struct packed {
    logic        we;
    logic        tpm;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [31:0] resp;   // SYNC script, nibble 0 first; last nibble repeats forever
    logic [3:0]  nresp;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic [11:0] lat;    // cycles from START to done_o
    logic [1:0]  st;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic lf, input logic oe, input logic [3:0] lad,
                      input logic [3:0] din);
    tr_t e;
    e.lf  = lf;
    e.oe  = oe;
    e.lad = lad;
    e.din = din;
    trace_q.push_back(e);
  endtask

  // Builds the expected cycle trace of one transaction from the protocol rules.
  task automatic build(input logic we, input logic tpm, input logic [15:0] addr,
                       input logic [7:0] wd, input logic [31:0] resp, input int nresp,
                       input logic [3:0] d0, input logic [3:0] d1,
                       output int n, output logic [1:0] st, output logic [7:0] rd);
    int waits = 0;
    int nr = 0;
    int outc = -1;
    logic [3:0] nib;
    trace_q.delete();
    push(1'b0, 1'b1, tpm ? 4'h5 : 4'h0, 4'($urandom));
    push(1'b1, 1'b1, we ? 4'h2 : 4'h0, 4'($urandom));
    for (int i = 3; i >= 0; i--) push(1'b1, 1'b1, addr[4*i+:4], 4'($urandom));
    if (we) begin
      push(1'b1, 1'b1, wd[3:0], 4'($urandom));
      push(1'b1, 1'b1, wd[7:4], 4'($urandom));
    end
    push(1'b1, 1'b1, 4'hF, 4'($urandom));
    push(1'b1, 1'b0, 4'hF, 4'($urandom));
    for (int j = 0; j < 4000 && outc < 0; j++) begin
      nib = (j < nresp) ? resp[4*j+:4] : resp[4*(nresp-1)+:4];
      push(1'b1, 1'b0, 4'hF, nib);
      if (nib == 4'h0) outc = 0;
      else if (nib == 4'hA) outc = 1;
      else if (nib == 4'h5 || nib == 4'h6) begin
        waits++;
        nr = 0;
        if (waits >= WaitMax) outc = 2;
      end else if (nib == 4'hF) begin
        nr++;
        if (nr >= NoResp) outc = 2;
      end else outc = 3;
    end
    if (outc <= 1) begin
      if (!we) begin
        push(1'b1, 1'b0, 4'hF, d0);
        push(1'b1, 1'b0, 4'hF, d1);
        rd_model = {d1, d0};
      end
      push(1'b1, 1'b0, 4'hF, 4'($urandom));
      push(1'b1, 1'b0, 4'hF, 4'($urandom));
    end else begin
      for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 4'hF, 4'($urandom));
      push(1'b1, 1'b1, 4'hF, 4'($urandom));
    end
    n  = trace_q.size();
    st = 2'(outc);
    rd = rd_model;
  endtask

  // Call at a falling edge with the DUT idle; returns at the falling edge of the done cycle
  // (chain=1) or one cycle later.
  task automatic run_txn(input logic we, input logic tpm, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [31:0] resp, input int nresp,
                         input logic [3:0] d0, input logic [3:0] d1, input bit use_tbl,
                         input int t_lat, input logic [1:0] t_st, input logic [7:0] t_rd,
                         input bit chain);
    int n;
    int k;
    logic [1:0] mst;
    logic [7:0] mrd;
    tr_t e;
    build(we, tpm, addr, wd, resp, nresp, d0, d1, n, mst, mrd);
    req_i       = 1'b1;
    req_we_i    = we;
    req_tpm_i   = tpm;
    req_addr_i  = addr;
    req_wdata_i = wd;
    @(negedge clk);
    k = 0;
    while (!done_o && k < 3000) begin
      if (k < n) begin
        e = trace_q[k];
        chk($sformatf("trace c%0d", k),
            {26'd0, busy_o, done_o, lframe_n, lad_oe, lad_oe ? lad_out : 4'h0},
            {26'd0, 1'b1, 1'b0, e.lf, e.oe, e.oe ? e.lad : 4'h0});
        lad_in = e.din;
      end else begin
        lad_in = 4'($urandom);
      end
      // Request lines are noise while busy; they must be ignored.
      req_i       = 1'($urandom);
      req_we_i    = 1'($urandom);
      req_tpm_i   = 1'($urandom);
      req_addr_i  = 16'($urandom);
      req_wdata_i = 8'($urandom);
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      miscompares++;
      $display("FAIL done timeout: no done_o within 3000 cycles");
    end
    chk("latency", 32'(k), use_tbl ? 32'(t_lat) : 32'(n));
    chk("done cycle", {27'd0, busy_o, done_o, lframe_n, lad_oe, lad_out[3]},
        {27'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
    chk("done lad", {28'd0, lad_out}, 32'hF);
    chk("status", {30'd0, status_o}, {30'd0, use_tbl ? t_st : mst});
    chk("rdata", {24'd0, rdata_o}, {24'd0, use_tbl ? t_rd : mrd});
    req_i  = 1'b0;
    lad_in = 4'hF;
    if (!chain) begin
      @(negedge clk);
      chk("idle after done", {24'd0, busy_o, done_o, lframe_n, lad_oe, lad_out},
          {24'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF});
    end
  endtask

  initial begin
    // we tpm addr wd resp nresp d0 d1 lat st rd
    tbl[0] = '{1'b1, 1'b0, 16'h0080, 8'hA5, 32'h0,         4'd1, 4'h0, 4'h0, 12'd13,
               2'b00, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 16'h0024, 8'h00, 32'h0000_0555, 4'd4, 4'hC, 4'h3, 12'd16,
               2'b00, 8'h3C};
    tbl[2] = '{1'b0, 1'b0, 16'h0060, 8'h00, 32'hF,         4'd1, 4'h1, 4'h1, 12'd17,
               2'b10, 8'h3C};
    tbl[3] = '{1'b1, 1'b0, 16'h0070, 8'h5A, 32'hA,         4'd1, 4'h0, 4'h0, 12'd13,
               2'b01, 8'h3C};
    tbl[4] = '{1'b0, 1'b0, 16'h0090, 8'h00, 32'h6,         4'd1, 4'h2, 4'h2, 12'd1036,
               2'b10, 8'h3C};
    tbl[5] = '{1'b0, 1'b1, 16'h00A0, 8'h00, 32'h3,         4'd1, 4'h2, 4'h2, 12'd14,
               2'b11, 8'h3C};
    tbl[6] = '{1'b0, 1'b0, 16'h1234, 8'h00, 32'h0,         4'd1, 4'h7, 4'hE, 12'd13,
               2'b00, 8'hE7};
    tbl[7] = '{1'b0, 1'b1, 16'hFFFE, 8'h00, 32'h0000_0A55, 4'd3, 4'h1, 4'h2, 12'd15,
               2'b01, 8'h21};
    tbl[8] = '{1'b0, 1'b0, 16'h8001, 8'h00, 32'h0FFF_5FFF, 4'd8, 4'h6, 4'h9, 12'd20,
               2'b00, 8'h96};

    rst_n = 1'b0;
    req_i = 1'b0; req_we_i = 1'b0; req_tpm_i = 1'b0;
    req_addr_i = 16'h0; req_wdata_i = 8'h0; lad_in = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst done", {31'd0, done_o}, 32'd0);
    chk("rst rdata", {24'd0, rdata_o}, 32'h00);
    chk("rst status", {30'd0, status_o}, 32'd0);
    chk("rst lad", {28'd0, lad_out}, 32'hF);
    chk("rst oe", {31'd0, lad_oe}, 32'd1);
    chk("rst lframe", {31'd0, lframe_n}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table; entries run back to back, so each request arrives in the done cycle.
    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].we, tbl[i].tpm, tbl[i].addr, tbl[i].wd, tbl[i].resp,
              int'(tbl[i].nresp), tbl[i].d0, tbl[i].d1, 1'b1, int'(tbl[i].lat),
              tbl[i].st, tbl[i].rd, (i != 8));
    end

    // Reset in the middle of ADDR, with a req pulse while busy beforehand.
    req_i = 1'b1; req_we_i = 1'b1; req_tpm_i = 1'b0;
    req_addr_i = 16'h5A5A; req_wdata_i = 8'h33;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    chk("pre-reset busy", {31'd0, busy_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst outputs",
        {16'd0, busy_o, done_o, rdata_o, status_o, lad_out, lad_oe, lframe_n},
        {16'd0, 1'b0, 1'b0, 8'h00, 2'b00, 4'hF, 1'b1, 1'b1});
    @(negedge clk);
    rst_n    = 1'b1;
    rd_model = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post-reset idle", {24'd0, busy_o, done_o, lframe_n, lad_oe, lad_out},
          {24'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF});
    end

    // Randomized transactions against the trace model.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] resp;
      int          nresp;
      logic [3:0]  nib;
      int          r;
      nresp = $urandom_range(1, 6);
      resp  = 32'h0;
      for (int j = 0; j < nresp - 1; j++) begin
        r = $urandom_range(0, 9);
        if (r < 4) nib = 4'h5;
        else if (r < 5) nib = 4'h6;
        else if (r < 8) nib = 4'hF;
        else nib = 4'($urandom);
        resp[4*j+:4] = nib;
      end
      r = $urandom_range(0, 9);
      if (r < 5) nib = 4'h0;
      else if (r < 7) nib = 4'hA;
      else if (r < 8) nib = 4'hF;
      else nib = 4'($urandom_range(1, 4));
      resp[4*(nresp-1)+:4] = nib;
      run_txn(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), resp, nresp,
              4'($urandom), 4'($urandom), 1'b0, 0, 2'b00, 8'h00, 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap idle", {24'd0, busy_o, done_o, lframe_n, lad_oe, lad_out},
            {24'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
